// File: rtl/alu_pkg.sv
// Shared ALU control definitions: control codes, ROM address width and the
// {funct7[5], funct3} encodings, plus the ROM lookup used by alu_rom.
package alu_pkg;

    localparam int ALU_ADDR_W = 4;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    // Address = {funct7[5], funct3[2:0]}
    localparam logic [ALU_ADDR_W-1:0] ADDR_ADD  = 4'b0000;
    localparam logic [ALU_ADDR_W-1:0] ADDR_SUB  = 4'b1000;
    localparam logic [ALU_ADDR_W-1:0] ADDR_SLL  = 4'b0001;
    localparam logic [ALU_ADDR_W-1:0] ADDR_SLT  = 4'b0010;
    localparam logic [ALU_ADDR_W-1:0] ADDR_SLTU = 4'b0011;
    localparam logic [ALU_ADDR_W-1:0] ADDR_XOR  = 4'b0100;
    localparam logic [ALU_ADDR_W-1:0] ADDR_SRL  = 4'b0101;
    localparam logic [ALU_ADDR_W-1:0] ADDR_SRA  = 4'b1101;
    localparam logic [ALU_ADDR_W-1:0] ADDR_OR   = 4'b0110;
    localparam logic [ALU_ADDR_W-1:0] ADDR_AND  = 4'b0111;

    // Unused addresses fall back to ADD; no error indication is produced.
    function automatic alu_op_e alu_rom_lookup(input logic [ALU_ADDR_W-1:0] a);
        case (a)
            ADDR_ADD:  return ALU_ADD;
            ADDR_SUB:  return ALU_SUB;
            ADDR_SLL:  return ALU_SLL;
            ADDR_SLT:  return ALU_SLT;
            ADDR_SLTU: return ALU_SLTU;
            ADDR_XOR:  return ALU_XOR;
            ADDR_SRL:  return ALU_SRL;
            ADDR_SRA:  return ALU_SRA;
            ADDR_OR:   return ALU_OR;
            ADDR_AND:  return ALU_AND;
            default:   return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/alu_rom.sv
// Registered ALU control ROM: translates {funct7[5], funct3} into an ALU
// control code one cycle later, zero-extended to Control_bits.
module alu_rom
    import alu_pkg::*;
#(
    parameter int Control_bits = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ALU_ADDR_W-1:0]   addr,
    output logic [Control_bits-1:0] alu_ctrl_out
);

    generate
        if (Control_bits < 4) begin : g_bad_width
            $error("alu_rom: Control_bits must be >= 4");
        end
    endgenerate

    logic [3:0]              w_code;
    logic [Control_bits-1:0] r_ctrl;

    assign w_code = alu_rom_lookup(addr);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl <= '0;
        end else begin
            r_ctrl <= Control_bits'(w_code);
        end
    end

    assign alu_ctrl_out = r_ctrl;

endmodule

// File: tb/tb_alu_rom.sv
// Self-checking bench for alu_rom: scoreboard of expected codes pushed on
// drive and popped one edge later, plus reset, latency, width and hold cases.
module tb_alu_rom;

    logic       clk;
    logic       reset;
    logic [3:0] addr;
    logic [3:0] out4;
    logic [7:0] out8;

    int n_checks;
    int n_errors;

    logic [3:0] exp_q[$];
    logic [3:0] ref_tbl[16];

    alu_rom #(.Control_bits(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .alu_ctrl_out (out4)
    );

    alu_rom #(.Control_bits(8)) dut8 (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .alu_ctrl_out (out8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a);
        @(negedge clk);
        addr = a;
        exp_q.push_back(ref_tbl[a]);
    endtask

    task automatic sample(input string tag);
        logic [3:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, {28'd0, out4}, {28'd0, e});
            check({tag, "_w8"}, {24'd0, out8}, {28'd0, e});
        end
    endtask

    initial begin
        // Reference table written straight from the opcode list.
        foreach (ref_tbl[i]) ref_tbl[i] = 4'd0;
        ref_tbl[0]  = 4'd0;  ref_tbl[8]  = 4'd1;
        ref_tbl[1]  = 4'd2;  ref_tbl[2]  = 4'd3;
        ref_tbl[3]  = 4'd4;  ref_tbl[4]  = 4'd5;
        ref_tbl[5]  = 4'd6;  ref_tbl[13] = 4'd7;
        ref_tbl[6]  = 4'd8;  ref_tbl[7]  = 4'd9;

        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        addr  = 4'b0111;

        // Reset state, and held through clock edges.
        #2;
        check("rst_async", {28'd0, out4}, 32'd0);
        check("rst_async_w8", {24'd0, out8}, 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_hold", {28'd0, out4}, 32'd0);
        end

        @(negedge clk);
        reset = 1'b0;

        // Sweep every address, one per cycle.
        for (int a = 0; a < 16; a++) begin
            drive(4'(a));
            sample($sformatf("sweep_%0d", a));
        end

        // Latency: mid-cycle addr change is invisible until the next edge.
        drive(4'b0000);
        sample("lat_add");
        #2;
        addr = 4'b1000;
        #1;
        check("lat_before_edge", {28'd0, out4}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_after_edge", {28'd0, out4}, 32'd1);

        // Mid-run reset pulse between edges.
        drive(4'b1101);
        sample("mid_sra");
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_async", {28'd0, out4}, 32'd0);
        check("mid_rst_async_w8", {24'd0, out8}, 32'd0);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_released", {28'd0, out4}, 32'd0);
        @(posedge clk);
        #1;
        check("mid_rst_reload", {28'd0, out4}, 32'd7);

        // Width: zero extension into the 8-bit instance.
        drive(4'b0111);
        sample("width_and");
        check("width_w8_and", {24'd0, out8}, 32'h09);

        // Hold: constant address, sampled either side of each edge.
        drive(4'b0100);
        sample("hold_first");
        repeat (10) begin
            @(negedge clk);
            #4;
            check("hold_pre_edge", {28'd0, out4}, 32'd5);
            @(posedge clk);
            #1;
            check("hold_post_edge", {28'd0, out4}, 32'd5);
        end

        if (exp_q.size() != 0) check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
